// File: rtl/pipe_pkg.sv
// Shared types and defaults for the skid-buffered pipeline register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int unsigned CTRL_W_DEF = 16;
    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP_DEF = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register (main + skid) with registered in_ready,
// flush-to-bubble on the control bundle and a saturating stall counter.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W   = 64,
    parameter int unsigned        CTRL_W   = CTRL_W_DEF,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = CTRL_W'(CTRL_NOP_DEF),
    parameter int unsigned        CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              clr_cnt
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              accept_c;
    logic              xfer_c;

    assign accept_c = in_valid & in_ready_q;
    assign xfer_c   = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        state_d     = ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ONE: begin
                    if (accept_c && xfer_c) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (accept_c) begin
                        state_d     = TWO;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (xfer_c) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (xfer_c) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        // Bubble the control bundle whenever nothing is presented; data keeps its value.
        if (state_d == EMPTY) begin
            main_ctrl_d = CTRL_NOP;
        end
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_NOP;
            skid_data_q <= '0;
            skid_ctrl_q <= CTRL_NOP;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid_q & ~out_ready),
        .clr (clr_cnt),
        .cnt (stall_cnt)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector bench for pipe_skid_reg: streaming, backpressure, flush,
// reset in TWO, and stall counter saturation/clear on a narrow-counter instance.
module tb_pipe_skid_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default widths, zero bubble encoding.
    logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clr;
    logic [63:0] a_in_data, a_out_data;
    logic [15:0] a_in_ctrl, a_out_ctrl, a_stall_cnt;

    pipe_skid_reg u_dut_a (
        .clk       (clk),
        .rst       (a_rst),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_ctrl   (a_in_ctrl),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_ctrl  (a_out_ctrl),
        .stall_cnt (a_stall_cnt),
        .clr_cnt   (a_clr)
    );

    // Instance B: 4-bit counter and non-zero bubble encoding.
    logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clr;
    logic [7:0]  b_in_data, b_out_data;
    logic [15:0] b_in_ctrl, b_out_ctrl;
    logic [3:0]  b_stall_cnt;

    pipe_skid_reg #(
        .DATA_W   (8),
        .CTRL_W   (16),
        .CTRL_NOP (16'hA5A5),
        .CNT_W    (4)
    ) u_dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_ctrl   (b_in_ctrl),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_ctrl  (b_out_ctrl),
        .stall_cnt (b_stall_cnt),
        .clr_cnt   (b_clr)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [63:0] din;
        logic        ordy;
        logic        clr;
        logic        ov;
        logic        ir;
        logic [63:0] dout;
        logic [15:0] ctrl;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic rst, input logic flush, input logic iv,
                                input logic [63:0] din, input logic ordy, input logic clr,
                                input logic ov, input logic ir, input logic [63:0] dout,
                                input logic [15:0] ctrl, input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.flush = flush; v.iv = iv; v.din = din; v.ordy = ordy; v.clr = clr;
        v.ov = ov; v.ir = ir; v.dout = dout; v.ctrl = ctrl; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step_b();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_in_ctrl = '0;
        a_out_ready = 1'b0; a_clr = 1'b0;
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_ctrl = '0;
        b_out_ready = 1'b0; b_clr = 1'b0;

        // rst flush iv din ordy clr | ov ir dout ctrl cnt  (in_ctrl = 0x1000 | din)
        vecs.push_back(mk(1,0,0,64'h0, 0,0, 0,1,64'h0, 16'h0,    0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0,0,1,64'(k),1,0, 1,1,64'(k), 16'h1000 | 16'(k), 0));
        vecs.push_back(mk(0,0,0,64'h0, 1,0, 0,1,64'h8,  16'h0,    0));
        // Backpressure: A into main, B into skid, extra beat refused while full.
        vecs.push_back(mk(0,0,1,64'hA, 0,0, 1,1,64'hA,  16'h100A, 0));
        vecs.push_back(mk(0,0,1,64'hB, 0,0, 1,0,64'hA,  16'h100A, 1));
        vecs.push_back(mk(0,0,1,64'hF, 0,0, 1,0,64'hA,  16'h100A, 2));
        vecs.push_back(mk(0,0,0,64'h0, 1,0, 1,1,64'hB,  16'h100B, 2));
        vecs.push_back(mk(0,0,0,64'h0, 1,0, 0,1,64'hB,  16'h0,    2));
        // Flush while TWO with a beat (0xC) on the input.
        vecs.push_back(mk(0,0,1,64'h11,0,0, 1,1,64'h11, 16'h1011, 2));
        vecs.push_back(mk(0,0,1,64'h12,0,0, 1,0,64'h11, 16'h1011, 3));
        vecs.push_back(mk(0,1,1,64'hC, 0,0, 0,1,64'h11, 16'h0,    4));
        vecs.push_back(mk(0,0,0,64'h0, 1,0, 0,1,64'h11, 16'h0,    4));
        vecs.push_back(mk(0,1,0,64'h0, 1,0, 0,1,64'h11, 16'h0,    4));
        vecs.push_back(mk(0,1,1,64'h13,1,0, 0,1,64'h11, 16'h0,    4));
        vecs.push_back(mk(0,0,0,64'h0, 1,1, 0,1,64'h11, 16'h0,    0));
        // Reset while TWO: both entries discarded, nothing emitted after.
        vecs.push_back(mk(0,0,1,64'h21,0,0, 1,1,64'h21, 16'h1021, 0));
        vecs.push_back(mk(0,0,1,64'h22,0,0, 1,0,64'h21, 16'h1021, 1));
        vecs.push_back(mk(1,0,1,64'h23,0,0, 0,1,64'h0,  16'h0,    0));
        vecs.push_back(mk(0,0,0,64'h0, 1,0, 0,1,64'h0,  16'h0,    0));

        for (int i = 0; i < vecs.size(); i++) begin
            a_rst       = vecs[i].rst;
            a_flush     = vecs[i].flush;
            a_in_valid  = vecs[i].iv;
            a_in_data   = vecs[i].din;
            a_in_ctrl   = 16'h1000 | vecs[i].din[15:0];
            a_out_ready = vecs[i].ordy;
            a_clr       = vecs[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 64'(a_out_valid), 64'(vecs[i].ov));
            check($sformatf("v%0d in_ready",  i), 64'(a_in_ready),  64'(vecs[i].ir));
            check($sformatf("v%0d out_data",  i), a_out_data,       vecs[i].dout);
            check($sformatf("v%0d out_ctrl",  i), 64'(a_out_ctrl),  64'(vecs[i].ctrl));
            check($sformatf("v%0d stall_cnt", i), 64'(a_stall_cnt), 64'(vecs[i].cnt));
        end
        a_rst = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_clr = 1'b0;

        // Instance B: reset state carries the custom bubble encoding.
        step_b();
        check("b reset out_ctrl", 64'(b_out_ctrl),  64'h A5A5);
        check("b reset cnt",      64'(b_stall_cnt), 64'h0);
        b_rst = 1'b0;
        b_in_valid = 1'b1; b_in_data = 8'h55; b_in_ctrl = 16'h0055;
        step_b();
        check("b load out_valid", 64'(b_out_valid), 64'h1);
        check("b load out_ctrl",  64'(b_out_ctrl),  64'h0055);
        b_in_valid = 1'b0;
        for (int s = 1; s <= 20; s++) begin
            step_b();
            if (s == 15 || s == 20)
                check($sformatf("b sat cnt after %0d", s), 64'(b_stall_cnt), 64'd15);
        end
        b_clr = 1'b1;
        step_b();
        check("b clr over stall", 64'(b_stall_cnt), 64'h0);
        b_clr = 1'b0;
        step_b();
        check("b count after clr", 64'(b_stall_cnt), 64'h1);
        b_flush = 1'b1;
        step_b();
        b_flush = 1'b0;
        check("b flush out_valid", 64'(b_out_valid), 64'h0);
        check("b flush out_ctrl",  64'(b_out_ctrl),  64'hA5A5);
        check("b flush out_data",  64'(b_out_data),  64'h55);
        check("b flush cnt",       64'(b_stall_cnt), 64'h2);
        step_b();
        check("b idle cnt hold",   64'(b_stall_cnt), 64'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
